instr_fetch_unit: RTL

- Fetch stage directly upstream of the single-cycle MIPS datapath.
- Takes the datapath's current `pc` and returns the 32-bit `instr` for that address.
- Uses a variable-latency instruction memory with a req/ack + rvalid handshake.
- Keeps a one-entry instruction buffer, so re-fetching the same address hits with zero stall. On a miss it asserts `stall`, and the datapath's pc register must hold.

---
 rtl/instr_fetch_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one-entry instruction buffer in front of a
// variable-latency req/ack + rvalid instruction memory.
module instr_fetch_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic             invalidate,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic             stall,
  output logic             misalign,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t      state, state_nxt;
  logic        buf_valid;
  logic [29:0] buf_tag;
  logic [31:0] buf_data;
  logic        hit;
  logic        fill;

  assign hit = buf_valid && (buf_tag == pc[31:2]);

  // Next state plus the combinational instr/stall view; a WAIT return is
  // forwarded straight to the datapath in the cycle rvalid arrives.
  always_comb begin
    state_nxt   = state;
    instr       = '0;
    instr_valid = 1'b0;
    stall       = 1'b1;
    fill        = 1'b0;
    case (state)
      IDLE: begin
        if (pc[1:0] != 2'b00) begin
          state_nxt = ERR;
        end else if (hit) begin
          instr       = buf_data;
          instr_valid = 1'b1;
          stall       = 1'b0;
        end else begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_ack) state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          instr       = mem_rdata;
          instr_valid = 1'b1;
          stall       = 1'b0;
          fill        = 1'b1;
          state_nxt   = IDLE;
        end
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      buf_valid   <= 1'b0;
      buf_tag     <= '0;
      buf_data    <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      misalign    <= 1'b0;
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      state   <= state_nxt;
      mem_req <= (state_nxt == REQ);
      if (state == IDLE && state_nxt == REQ) mem_addr <= {pc[31:2], 2'b00};
      if (state == IDLE && state_nxt == ERR) misalign <= 1'b1;
      // The tag comes from the latched request address, not the live pc.
      if (fill) begin
        buf_tag   <= mem_addr[31:2];
        buf_data  <= mem_rdata;
        buf_valid <= 1'b1;
      end
      if (invalidate) buf_valid <= 1'b0;
      if (fill && fetch_count != CNT_MAX) fetch_count <= fetch_count + CNT_ONE;
      if (stall && state != ERR && stall_count != CNT_MAX)
        stall_count <= stall_count + CNT_ONE;
    end
  end

endmodule
